ibex_rf_wb_arbiter: RTL and testbench

Sequences the single register-file write port (waddr/wdata/we) between two producers: single-cycle EX results and in-order LSU load responses. Tracks outstanding loads in a small scoreboard so ID can stall reads of pending destinations (RAW). EX writes that would overtake an older load to the same register are held off (WAW). Sits between the ID/EX/LSU stages and the flip-flop register file.

---
 rtl/ibex_pkg.sv | 12 +
 rtl/ibex_rf_wb_sb.sv | 92 +++++++++
 rtl/ibex_rf_wb_arbiter.sv | 118 +++++++++++
 tb/tb_ibex_rf_wb_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared ibex types used by the register-file writeback path.
// Holds the load scoreboard entry layout.
package ibex_pkg;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        data_valid;
      logic        err;
   } rf_wb_sb_entry_t;

endpackage

// File: rtl/ibex_rf_wb_sb.sv
// Load scoreboard: in-order storage, issue/fill/retire pointers, rd match.
// Ports: issue/rsp inputs, 3 query addrs; head entry, full, match vectors.
import ibex_pkg::*;

module ibex_rf_wb_sb #(
   parameter int unsigned MaxOutstanding = 2,
   parameter int unsigned PtrW           = $clog2(MaxOutstanding) + 1
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           issue_i,
   input  logic [4:0]                     issue_rd_i,
   input  logic                           rsp_i,
   input  logic [31:0]                    rsp_data_i,
   input  logic                           rsp_err_i,
   input  logic [2:0][4:0]                q_addr_i,
   output rf_wb_sb_entry_t                head_o,
   output logic                           head_valid_o,
   output logic                           full_o,
   output logic                           spurious_o,
   output logic [2:0][MaxOutstanding-1:0] match_o
);

   localparam int unsigned IdxW = PtrW - 1;

   rf_wb_sb_entry_t           mem_q [MaxOutstanding];
   logic [PtrW-1:0]           iss_q, rsp_q, ret_q, used;
   logic [IdxW-1:0]           iss_idx, rsp_idx, ret_idx;
   logic [MaxOutstanding-1:0] alloc;
   logic                      rsp_ok;

   assign iss_idx = iss_q[IdxW-1:0];
   assign rsp_idx = rsp_q[IdxW-1:0];
   assign ret_idx = ret_q[IdxW-1:0];
   assign used    = iss_q - ret_q;

   assign full_o = (iss_idx == ret_idx) &&
                   (iss_q[PtrW-1] != ret_q[PtrW-1]);

   // Entries between ret and rsp have data and retire one per cycle.
   assign head_valid_o = (rsp_q != ret_q);
   assign head_o       = mem_q[ret_idx];

   // A response is only legal while some entry still awaits data.
   assign rsp_ok     = rsp_i && (rsp_q != iss_q);
   assign spurious_o = rsp_i && (rsp_q == iss_q);

   // Slot i is live if its distance from the retire slot is below used.
   always_comb begin
      alloc = '0;
      for (int i = 0; i < MaxOutstanding; i++) begin
         alloc[i] = {1'b0, IdxW'(IdxW'(i) - ret_idx)} < used;
      end
   end

   always_comb begin
      match_o = '0;
      for (int q = 0; q < 3; q++) begin
         for (int i = 0; i < MaxOutstanding; i++) begin
            match_o[q][i] = alloc[i] && (mem_q[i].rd == q_addr_i[q]);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         iss_q <= '0;
         rsp_q <= '0;
         ret_q <= '0;
         for (int i = 0; i < MaxOutstanding; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (issue_i) begin
            mem_q[iss_idx].rd         <= issue_rd_i;
            mem_q[iss_idx].data_valid <= 1'b0;
            mem_q[iss_idx].err        <= 1'b0;
            iss_q                     <= iss_q + PtrW'(1);
         end
         if (rsp_ok) begin
            mem_q[rsp_idx].data       <= rsp_data_i;
            mem_q[rsp_idx].err        <= rsp_err_i;
            mem_q[rsp_idx].data_valid <= 1'b1;
            rsp_q                     <= rsp_q + PtrW'(1);
         end
         if (head_valid_o) begin
            ret_q <= ret_q + PtrW'(1);
         end
      end
   end

endmodule

// File: rtl/ibex_rf_wb_arbiter.sv
// RF write-port arbiter: in-order load retire beats single-cycle EX writes.
// Ports: EX result, load issue/response, ID read hazards, RF write port.
import ibex_pkg::*;

module ibex_rf_wb_arbiter #(
   parameter bit          RV32E          = 1'b0,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 ex_valid_i,
   input  logic [4:0]           ex_waddr_i,
   input  logic [DataWidth-1:0] ex_wdata_i,
   output logic                 ex_ready_o,
   input  logic                 ld_issue_i,
   input  logic [4:0]           ld_issue_waddr_i,
   output logic                 ld_issue_ready_o,
   input  logic                 lsu_rvalid_i,
   input  logic [DataWidth-1:0] lsu_rdata_i,
   input  logic                 lsu_err_i,
   input  logic [4:0]           raddr_a_i,
   input  logic [4:0]           raddr_b_i,
   output logic                 hazard_a_o,
   output logic                 hazard_b_o,
   output logic [4:0]           rf_waddr_o,
   output logic [DataWidth-1:0] rf_wdata_o,
   output logic                 rf_we_o,
   output logic                 spurious_rvalid_o
);

   localparam int unsigned RfWbPtrW = $clog2(MaxOutstanding) + 1;

   rf_wb_sb_entry_t                head;
   logic                           head_valid, full, issue_en;
   logic                           ld_retiring, waw, active_q;
   logic [2:0][MaxOutstanding-1:0] match;
   logic [4:0]                     waddr_q;
   logic [DataWidth-1:0]           wdata_q;

   // x0 and, on RV32E, x16..x31 are never written nor tracked.
   function automatic logic addr_ok(input logic [4:0] a);
      return (a != 5'd0) && !(RV32E && a[4]);
   endfunction

   assign ld_issue_ready_o = !full;
   assign issue_en         = ld_issue_i && !full;

   ibex_rf_wb_sb #(
      .MaxOutstanding (MaxOutstanding),
      .PtrW           (RfWbPtrW)
   ) u_sb (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .issue_i      (issue_en),
      .issue_rd_i   (ld_issue_waddr_i),
      .rsp_i        (lsu_rvalid_i),
      .rsp_data_i   (32'(lsu_rdata_i)),
      .rsp_err_i    (lsu_err_i),
      .q_addr_i     ({ex_waddr_i, raddr_b_i, raddr_a_i}),
      .head_o       (head),
      .head_valid_o (head_valid),
      .full_o       (full),
      .spurious_o   (spurious_rvalid_o),
      .match_o      (match)
   );

   assign ld_retiring = head_valid && head.data_valid;

   // EX must not overtake an older load to the same register.
   assign waw = addr_ok(ex_waddr_i) && |match[2];

   assign hazard_a_o = addr_ok(raddr_a_i) && |match[0];
   assign hazard_b_o = addr_ok(raddr_b_i) && |match[1];

   assign ex_ready_o = active_q && ex_valid_i && !ld_retiring && !waw;

   always_comb begin
      rf_we_o    = 1'b0;
      rf_waddr_o = waddr_q;
      rf_wdata_o = wdata_q;
      unique case (1'b1)
         ld_retiring: begin
            rf_we_o    = !head.err && addr_ok(head.rd);
            rf_waddr_o = head.rd;
            rf_wdata_o = DataWidth'(head.data);
         end
         ex_ready_o: begin
            rf_we_o    = addr_ok(ex_waddr_i);
            rf_waddr_o = ex_waddr_i;
            rf_wdata_o = ex_wdata_i;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         active_q <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
      end else begin
         active_q <= 1'b1;
         waddr_q  <= rf_waddr_o;
         wdata_q  <= rf_wdata_o;
      end
   end

   issue_when_full_a: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      !(ld_issue_i && full));

   rv32e_addr_a: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      !(RV32E && ((ld_issue_i && ld_issue_waddr_i[4]) ||
                  (ex_valid_i && ex_waddr_i[4]))));

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Bench for ibex_rf_wb_arbiter: expected RF writes queued at stimulus time,
// popped by a negedge monitor; control outputs checked directly.
module tb_ibex_rf_wb_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        ex_valid_i, ex_ready_o;
   logic [4:0]  ex_waddr_i;
   logic [31:0] ex_wdata_i;
   logic        ld_issue_i, ld_issue_ready_o;
   logic [4:0]  ld_issue_waddr_i;
   logic        lsu_rvalid_i, lsu_err_i;
   logic [31:0] lsu_rdata_i;
   logic [4:0]  raddr_a_i, raddr_b_i;
   logic        hazard_a_o, hazard_b_o;
   logic [4:0]  rf_waddr_o;
   logic [31:0] rf_wdata_o;
   logic        rf_we_o, spurious_rvalid_o;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;

   always #5 clk_i = ~clk_i;

   ibex_rf_wb_arbiter dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .ex_valid_i        (ex_valid_i),
      .ex_waddr_i        (ex_waddr_i),
      .ex_wdata_i        (ex_wdata_i),
      .ex_ready_o        (ex_ready_o),
      .ld_issue_i        (ld_issue_i),
      .ld_issue_waddr_i  (ld_issue_waddr_i),
      .ld_issue_ready_o  (ld_issue_ready_o),
      .lsu_rvalid_i      (lsu_rvalid_i),
      .lsu_rdata_i       (lsu_rdata_i),
      .lsu_err_i         (lsu_err_i),
      .raddr_a_i         (raddr_a_i),
      .raddr_b_i         (raddr_b_i),
      .hazard_a_o        (hazard_a_o),
      .hazard_b_o        (hazard_b_o),
      .rf_waddr_o        (rf_waddr_o),
      .rf_wdata_o        (rf_wdata_o),
      .rf_we_o           (rf_we_o),
      .spurious_rvalid_o (spurious_rvalid_o)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic idle();
      ex_valid_i       = 1'b0;
      ex_waddr_i       = 5'd0;
      ex_wdata_i       = 32'd0;
      ld_issue_i       = 1'b0;
      ld_issue_waddr_i = 5'd0;
      lsu_rvalid_i     = 1'b0;
      lsu_rdata_i      = 32'd0;
      lsu_err_i        = 1'b0;
      raddr_a_i        = 5'd0;
      raddr_b_i        = 5'd0;
   endtask

   task automatic push(input logic [4:0] a, input logic [31:0] d);
      exp_q.push_back('{a: a, d: d});
   endtask

   always @(negedge clk_i) begin
      if (rst_ni && rf_we_o) begin
         if (exp_q.size() == 0) begin
            chk("unexp_we_addr", 32'(rf_waddr_o), 32'hFFFF_FFFF);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", 32'(rf_waddr_o), 32'(mon_e.a));
            chk("wr_data", rf_wdata_o, mon_e.d);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1);
   end

   initial begin
      idle();
      ex_valid_i = 1'b1;
      ex_waddr_i = 5'd1;
      @(posedge clk_i);
      #1;
      chk("rst_ex_ready", 32'(ex_ready_o), 0);
      chk("rst_we", 32'(rf_we_o), 0);
      chk("rst_waddr", 32'(rf_waddr_o), 0);
      chk("rst_wdata", rf_wdata_o, 0);
      chk("rst_ld_ready", 32'(ld_issue_ready_o), 1);
      chk("rst_haz_a", 32'(hazard_a_o), 0);
      chk("rst_haz_b", 32'(hazard_b_o), 0);
      chk("rst_spur", 32'(spurious_rvalid_o), 0);
      idle();
      tick();
      rst_ni = 1'b1;
      tick();

      // EX write goes straight through
      ex_valid_i = 1'b1;
      ex_waddr_i = 5'd5;
      ex_wdata_i = 32'hA5A5_A5A5;
      push(5'd5, 32'hA5A5_A5A5);
      settle();
      chk("ex_ready", 32'(ex_ready_o), 1);
      chk("ex_we", 32'(rf_we_o), 1);
      chk("ex_waddr", 32'(rf_waddr_o), 5);
      tick();
      idle();
      settle();
      chk("idle_we", 32'(rf_we_o), 0);
      chk("idle_hold_addr", 32'(rf_waddr_o), 5);
      chk("idle_hold_data", rf_wdata_o, 32'hA5A5_A5A5);

      // Load x7: hazard, retire latency
      tick();
      ld_issue_i       = 1'b1;
      ld_issue_waddr_i = 5'd7;
      raddr_a_i        = 5'd7;
      settle();
      chk("l7_ready", 32'(ld_issue_ready_o), 1);
      chk("l7_haz_pre", 32'(hazard_a_o), 0);
      tick();
      ld_issue_i = 1'b0;
      settle();
      chk("l7_haz", 32'(hazard_a_o), 1);
      tick();
      lsu_rvalid_i = 1'b1;
      lsu_rdata_i  = 32'h1234;
      push(5'd7, 32'h1234);
      settle();
      chk("l7_rv_we", 32'(rf_we_o), 0);
      tick();
      lsu_rvalid_i = 1'b0;
      settle();
      chk("l7_ret_we", 32'(rf_we_o), 1);
      chk("l7_ret_addr", 32'(rf_waddr_o), 7);
      chk("l7_ret_haz", 32'(hazard_a_o), 1);
      tick();
      settle();
      chk("l7_haz_clr", 32'(hazard_a_o), 0);

      // Two loads fill the scoreboard
      tick();
      idle();
      ld_issue_i       = 1'b1;
      ld_issue_waddr_i = 5'd3;
      tick();
      ld_issue_waddr_i = 5'd4;
      settle();
      chk("full_pre", 32'(ld_issue_ready_o), 1);
      tick();
      ld_issue_i = 1'b0;
      settle();
      chk("full", 32'(ld_issue_ready_o), 0);
      tick();
      lsu_rvalid_i = 1'b1;
      lsu_rdata_i  = 32'h33;
      push(5'd3, 32'h33);
      settle();
      chk("full_rv1", 32'(ld_issue_ready_o), 0);
      tick();
      lsu_rdata_i = 32'h44;
      push(5'd4, 32'h44);
      settle();
      chk("full_ret1", 32'(ld_issue_ready_o), 0);
      chk("full_ret1_addr", 32'(rf_waddr_o), 3);
      tick();
      lsu_rvalid_i = 1'b0;
      settle();
      chk("full_after_ret", 32'(ld_issue_ready_o), 1);
      chk("full_ret2_addr", 32'(rf_waddr_o), 4);

      // WAW: EX x9 held behind load x9
      tick();
      ld_issue_i       = 1'b1;
      ld_issue_waddr_i = 5'd9;
      tick();
      ld_issue_i = 1'b0;
      ex_valid_i = 1'b1;
      ex_waddr_i = 5'd9;
      ex_wdata_i = 32'h9999_9999;
      settle();
      chk("waw_block0", 32'(ex_ready_o), 0);
      tick();
      settle();
      chk("waw_block1", 32'(ex_ready_o), 0);
      tick();
      lsu_rvalid_i = 1'b1;
      lsu_rdata_i  = 32'h9000;
      push(5'd9, 32'h9000);
      push(5'd9, 32'h9999_9999);
      settle();
      chk("waw_block_rv", 32'(ex_ready_o), 0);
      tick();
      lsu_rvalid_i = 1'b0;
      settle();
      chk("waw_block_ret", 32'(ex_ready_o), 0);
      chk("waw_ret_data", rf_wdata_o, 32'h9000);
      tick();
      settle();
      chk("waw_accept", 32'(ex_ready_o), 1);
      chk("waw_ex_data", rf_wdata_o, 32'h9999_9999);
      tick();
      idle();

      // Load retire collides with unrelated EX write
      ld_issue_i       = 1'b1;
      ld_issue_waddr_i = 5'd11;
      tick();
      ld_issue_i   = 1'b0;
      lsu_rvalid_i = 1'b1;
      lsu_rdata_i  = 32'hB;
      push(5'd11, 32'hB);
      tick();
      lsu_rvalid_i = 1'b0;
      ex_valid_i   = 1'b1;
      ex_waddr_i   = 5'd2;
      ex_wdata_i   = 32'h22;
      push(5'd2, 32'h22);
      settle();
      chk("coll_ex_ready", 32'(ex_ready_o), 0);
      chk("coll_ld_addr", 32'(rf_waddr_o), 11);
      tick();
      settle();
      chk("coll_ex_next", 32'(ex_ready_o), 1);
      chk("coll_ex_addr", 32'(rf_waddr_o), 2);
      tick();
      idle();

      // Issue while head retires
      ld_issue_i       = 1'b1;
      ld_issue_waddr_i = 5'd13;
      tick();
      ld_issue_i   = 1'b0;
      lsu_rvalid_i = 1'b1;
      lsu_rdata_i  = 32'hD13;
      push(5'd13, 32'hD13);
      tick();
      lsu_rvalid_i     = 1'b0;
      ld_issue_i       = 1'b1;
      ld_issue_waddr_i = 5'd14;
      raddr_b_i        = 5'd14;
      settle();
      chk("ovl_ready", 32'(ld_issue_ready_o), 1);
      chk("ovl_ret_addr", 32'(rf_waddr_o), 13);
      tick();
      ld_issue_i   = 1'b0;
      lsu_rvalid_i = 1'b1;
      lsu_rdata_i  = 32'hD14;
      push(5'd14, 32'hD14);
      settle();
      chk("ovl_haz_b", 32'(hazard_b_o), 1);
      tick();
      idle();
      tick();

      // x0 load, error load, spurious response
      ld_issue_i       = 1'b1;
      ld_issue_waddr_i = 5'd0;
      tick();
      ld_issue_waddr_i = 5'd12;
      tick();
      ld_issue_i   = 1'b0;
      raddr_a_i    = 5'd0;
      raddr_b_i    = 5'd12;
      lsu_rvalid_i = 1'b1;
      lsu_rdata_i  = 32'h0F0F;
      settle();
      chk("x0_haz_a", 32'(hazard_a_o), 0);
      chk("x12_haz_b", 32'(hazard_b_o), 1);
      tick();
      lsu_err_i   = 1'b1;
      lsu_rdata_i = 32'hDEAD;
      settle();
      chk("x0_no_we", 32'(rf_we_o), 0);
      tick();
      lsu_rvalid_i = 1'b0;
      lsu_err_i    = 1'b0;
      settle();
      chk("err_no_we", 32'(rf_we_o), 0);
      chk("err_haz_b", 32'(hazard_b_o), 1);
      tick();
      settle();
      chk("err_haz_clr", 32'(hazard_b_o), 0);
      chk("err_ready", 32'(ld_issue_ready_o), 1);
      tick();
      lsu_rvalid_i = 1'b1;
      lsu_rdata_i  = 32'h5;
      settle();
      chk("spur_pulse", 32'(spurious_rvalid_o), 1);
      tick();
      lsu_rvalid_i = 1'b0;
      settle();
      chk("spur_clr", 32'(spurious_rvalid_o), 0);
      chk("spur_no_we", 32'(rf_we_o), 0);

      // Reset with a load outstanding
      tick();
      idle();
      ld_issue_i       = 1'b1;
      ld_issue_waddr_i = 5'd6;
      tick();
      ld_issue_i = 1'b0;
      raddr_a_i  = 5'd6;
      settle();
      chk("mid_haz", 32'(hazard_a_o), 1);
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_haz", 32'(hazard_a_o), 0);
      chk("mid_rst_ready", 32'(ld_issue_ready_o), 1);
      chk("mid_rst_waddr", 32'(rf_waddr_o), 0);
      tick();
      rst_ni = 1'b1;
      tick();
      settle();
      chk("post_rst_haz", 32'(hazard_a_o), 0);
      tick();
      tick();

      chk("exp_q_empty", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
